// File: rtl/pipe_stage_elastic_pkg.sv
// pipe_stage_elastic_pkg: shared occupancy encoding and per-stage field widths and safe control values
package pipe_stage_elastic_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } stage_occ_t;

    // MEM/WB carries {REG_W_En, Result_Src_Sel[2:0]} and RD + Data_Out_Ext + ALU_Out + PC_Plus_4
    localparam int                      MEMWB_CTRL_W    = 4;
    localparam int                      MEMWB_DATA_W    = 101;
    // Safe value keeps REG_W_En (and any memory write enable) deasserted
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_SAFE_CTRL = '0;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one {valid, ctrl, data} entry with load, clear-to-safe and hold
module pipe_slot #(
    parameter int                CTRL_W    = 4,
    parameter int                DATA_W    = 101,
    parameter logic [CTRL_W-1:0] SAFE_CTRL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Clear wins over load; clearing keeps stale data but forces ctrl to the safe value
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            ctrl_q  <= SAFE_CTRL;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= SAFE_CTRL;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline stage register with 2-entry skid buffer and synchronous flush
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int                CTRL_W    = MEMWB_CTRL_W,
    parameter int                DATA_W    = MEMWB_DATA_W,
    parameter logic [CTRL_W-1:0] SAFE_CTRL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Flush,
    input  logic              Valid_In,
    output logic              Ready_Out,
    input  logic [CTRL_W-1:0] Ctrl_In,
    input  logic [DATA_W-1:0] Data_In,
    output logic              Valid_Out,
    input  logic              Ready_In,
    output logic [CTRL_W-1:0] Ctrl_Out,
    output logic [DATA_W-1:0] Data_Out,
    output logic [1:0]        Occupancy
);

    stage_occ_t        state_q, state_d;
    logic              ready_q;
    logic              push, pop;
    logic              main_load, main_clr, main_from_skid, skid_load, skid_clr;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign push = Valid_In & ready_q;
    assign pop  = Valid_Out & Ready_In;

    // Next occupancy and slot controls; Flush overrides any push/pop
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (Flush) begin
            state_d  = OCC_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        state_d   = OCC_ONE;
                        main_load = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = OCC_FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d  = OCC_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (pop && skid_valid) begin
                        state_d        = OCC_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy register and registered ready derived from next occupancy, never from Ready_In
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= OCC_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != OCC_FULL);
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SAFE_CTRL(SAFE_CTRL)) u_main (
        .CLK     (CLK),
        .RST     (RST),
        .load_i  (main_load),
        .clear_i (main_clr),
        .ctrl_i  (main_from_skid ? skid_ctrl : Ctrl_In),
        .data_i  (main_from_skid ? skid_data : Data_In),
        .valid_o (Valid_Out),
        .ctrl_o  (Ctrl_Out),
        .data_o  (Data_Out)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SAFE_CTRL(SAFE_CTRL)) u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .ctrl_i  (Ctrl_In),
        .data_i  (Data_In),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    assign Ready_Out = ready_q;
    assign Occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench for the elastic stage with directed vectors
module tb_pipe_stage_elastic;

    localparam int CW = 4;
    localparam int DW = 101;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b1;
    logic          Flush    = 1'b0;
    logic          Valid_In = 1'b0;
    logic          Ready_In = 1'b0;
    logic [CW-1:0] Ctrl_In  = '0;
    logic [DW-1:0] Data_In  = '0;
    logic          Ready_Out, Valid_Out;
    logic [CW-1:0] Ctrl_Out;
    logic [DW-1:0] Data_Out;
    logic [1:0]    Occupancy;

    int               checks = 0;
    int               errors = 0;
    logic [CW+DW-1:0] exp_q[$];
    logic [CW+DW-1:0] e;

    pipe_stage_elastic dut (
        .CLK       (CLK),
        .RST       (RST),
        .Flush     (Flush),
        .Valid_In  (Valid_In),
        .Ready_Out (Ready_Out),
        .Ctrl_In   (Ctrl_In),
        .Data_In   (Data_In),
        .Valid_Out (Valid_Out),
        .Ready_In  (Ready_In),
        .Ctrl_Out  (Ctrl_Out),
        .Data_Out  (Data_Out),
        .Occupancy (Occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Offer one entry until accepted; the expected output is queued at the accepting edge
    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
        Valid_In = 1'b1;
        Ctrl_In  = c;
        Data_In  = d;
        for (int i = 0; i < 20; i++) begin
            if (Ready_Out) begin
                exp_q.push_back({c, d});
                cyc();
                Valid_In = 1'b0;
                return;
            end
            cyc();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: ctrl %0h never accepted", c);
        Valid_In = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, Valid_Out, 0);
        chk({tag, "_ctrl"},  Ctrl_Out,  0);
        chk({tag, "_data"},  Data_Out,  0);
        chk({tag, "_ready"}, Ready_Out, 1);
        chk({tag, "_occ"},   Occupancy, 0);
    endtask

    // Monitor: every downstream transfer must match the scoreboard head; empty stage must show safe ctrl
    always @(negedge CLK) begin
        if (!RST) begin
            if (Valid_Out && Ready_In) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got ctrl %0h data %0h with empty scoreboard", Ctrl_Out, Data_Out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_ctrl", Ctrl_Out, e[DW +: CW]);
                    chk("out_data", Data_Out, e[DW-1:0]);
                end
            end
            if (!Valid_Out) chk("safe_ctrl_when_empty", Ctrl_Out, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc();
        cyc();
        RST = 1'b0;
        chk_reset_state("reset");
        cyc();
        chk_reset_state("idle");

        Ready_In = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stream_ready", Ready_Out, 1);
            send(CW'(i + 1), DW'(8'hA0 + i));
            chk("stream_occ", Occupancy, 1);
            if (i == 0) begin
                chk("latency_valid", Valid_Out, 1);
                chk("latency_ctrl",  Ctrl_Out,  1);
            end
        end
        cyc();
        chk("stream_done_valid", Valid_Out, 0);
        chk("stream_done_occ",   Occupancy, 0);

        send(4'h3, 'hC3);
        chk("drain_valid_hi", Valid_Out, 1);
        chk("drain_ctrl_3",   Ctrl_Out,  3);
        cyc();
        chk("drain_valid_lo", Valid_Out, 0);
        chk("drain_ctrl_safe", Ctrl_Out, 0);

        Ready_In = 1'b0;
        send(4'h1, 'h11);
        chk("bp_occ_1",   Occupancy, 1);
        chk("bp_ready_1", Ready_Out, 1);
        send(4'h2, 'h22);
        chk("bp_occ_2",   Occupancy, 2);
        chk("bp_ready_0", Ready_Out, 0);
        Valid_In = 1'b1;
        Ctrl_In  = 4'h3;
        Data_In  = 'h33;
        cyc();
        chk("bp_hold_occ",   Occupancy, 2);
        chk("bp_hold_ready", Ready_Out, 0);
        chk("bp_head_ctrl",  Ctrl_Out,  1);
        Ready_In = 1'b1;
        send(4'h3, 'h33);
        cyc();
        cyc();
        chk("bp_drained_occ", Occupancy, 0);

        Ready_In = 1'b0;
        send(4'h4, 'hF1);
        send(4'h5, 'hF2);
        chk("flush_pre_occ", Occupancy, 2);
        Flush    = 1'b1;
        Valid_In = 1'b1;
        Ctrl_In  = 4'h6;
        Data_In  = 'hF3;
        cyc();
        Flush    = 1'b0;
        Valid_In = 1'b0;
        exp_q.delete();
        chk("flush_valid", Valid_Out, 0);
        chk("flush_ctrl",  Ctrl_Out,  0);
        chk("flush_occ",   Occupancy, 0);
        chk("flush_ready", Ready_Out, 1);
        Ready_In = 1'b1;
        repeat (3) cyc();
        chk("flush_nothing_emerges", Valid_Out, 0);

        Ready_In = 1'b0;
        send(4'h7, 'h77);
        Ready_In = 1'b1;
        Flush    = 1'b1;
        Valid_In = 1'b1;
        Ctrl_In  = 4'h8;
        Data_In  = 'h88;
        cyc();
        Flush    = 1'b0;
        Valid_In = 1'b0;
        chk("flush_pop_taken", exp_q.size(), 0);
        exp_q.delete();
        chk("flush_pop_occ",   Occupancy, 0);
        chk("flush_pop_valid", Valid_Out, 0);
        repeat (2) cyc();

        Ready_In = 1'b0;
        send(4'h9, 'h99);
        send(4'hA, 'hAA);
        chk("rst_pre_occ", Occupancy, 2);
        RST      = 1'b1;
        Flush    = 1'b1;
        Valid_In = 1'b1;
        Ctrl_In  = 4'hC;
        Data_In  = 'hCC;
        cyc();
        RST      = 1'b0;
        Flush    = 1'b0;
        Valid_In = 1'b0;
        exp_q.delete();
        chk_reset_state("midrst");
        Ready_In = 1'b1;
        send(4'hB, 'h1BB);
        chk("post_rst_valid", Valid_Out, 1);
        chk("post_rst_ctrl",  Ctrl_Out,  'hB);
        chk("post_rst_data",  Data_Out,  'h1BB);
        cyc();
        cyc();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One generic, elastic stage register carrying a control field and a data field between pipeline stages.
- Uses a valid/ready handshake, a 2-entry skid buffer for full throughput with registered Ready_Out, and synchronous flush.
- Control bits are forced to a parametrised safe value whenever the stage holds no valid entry.

Parameters:
- CTRL_W, 4, width of control field (e.g. {REG_W_En, Result_Src_Sel}).
- DATA_W, 101, width of data field (e.g. RD + Data_Out_Ext + ALU_Out + PC_Plus_4).
- SAFE_CTRL, '0, control value driven on Ctrl_Out when empty, after reset and after flush.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- Flush  in  1  synchronous kill of all held entries.
- Valid_In  in  1  upstream entry valid.
- Ready_Out  out  1  stage can accept; registered.
- Ctrl_In  in  CTRL_W  upstream control field.
- Data_In  in  DATA_W  upstream data field.
- Valid_Out  out  1  downstream entry valid.
- Ready_In  in  1  downstream accepts.
- Ctrl_Out  out  CTRL_W  head-entry control field.
- Data_Out  out  DATA_W  head-entry data field.
- Occupancy  out  2  held entries, 0..2.

Behaviour:
- Reset is synchronous, active-high; CLK is the clock.
- Storage: main slot (drives outputs) and skid slot; each holds {valid, ctrl, data}.
- push = Valid_In & Ready_Out; pop = Valid_Out & Ready_In.
- State follows Occupancy: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push -> ONE, main <= input.
  - ONE: push & pop -> ONE, main <= input. push & !pop -> FULL, skid <= input. !push & pop -> EMPTY. Otherwise hold.
  - FULL: pop -> ONE, main <= skid, skid cleared. Otherwise hold. push is impossible because Ready_Out=0.
- Ready_Out = (next state != FULL), registered, so Ready_Out is 1 in EMPTY and ONE and 0 in FULL.
- An upstream Valid_In with Ready_Out=0 is not consumed; upstream holds its data.
- Latency: 1 cycle from push in EMPTY to Valid_Out=1. Throughput: 1 entry/cycle sustained while Ready_In=1.
- Ordering: strict FIFO. No entry is duplicated or dropped except by Flush or RST.
- Whenever a slot becomes empty, its ctrl loads SAFE_CTRL. Invariant: Valid_Out=0 implies Ctrl_Out==SAFE_CTRL.
- Data_Out is 0 after reset. Otherwise it holds its last value when empty; data is don't-care when invalid.
- Flush (priority over push/pop in the same cycle): both slots invalid, ctrl=SAFE_CTRL, state EMPTY, Ready_Out=1 next cycle.
  - A same-cycle push is dropped.
  - A same-cycle pop still counts as taken by downstream (the current output was visible and valid).
- RST (priority over Flush): Valid_Out=0, Ctrl_Out=SAFE_CTRL, Data_Out=0, Occupancy=0, Ready_Out=1, skid cleared.
  - Reset mid-operation discards all entries.
- Downstream stall = Ready_In held 0. The stage fills to 2 entries and then backpressures.
- Ready_In may depend combinationally on Valid_Out. Ready_Out never depends combinationally on Ready_In.

Decomposition:
- Package definitions gets:
  - stage_occ_t enum {OCC_EMPTY, OCC_ONE, OCC_FULL}.
  - Per-stage SAFE_CTRL constants, e.g. MEMWB_SAFE_CTRL with REG_W_En=0 and DMEM_W_En=0.
  - Per-stage CTRL_W/DATA_W localparams.
- One sub-module, pipe_slot: {valid, ctrl, data} register with load, clear-to-safe and hold controls. Instantiate twice, as main and skid.

Test Plan:
- Reset, then idle: Valid_Out=0, Ctrl_Out=SAFE_CTRL(0x0), Data_Out=0, Ready_Out=1, Occupancy=0.
- Streaming, Ready_In=1: push ctrl 0x1..0x5 with data 0xA0..0xA4 on consecutive cycles -> outputs appear 1 cycle later, in order, one per cycle; Ready_Out stays 1.
- Backpressure: Ready_In=0, push 0x11, 0x22, 0x33 -> Occupancy reaches 2 and Ready_Out=0 after the 2nd push; 0x33 is held upstream. Release Ready_In -> output 0x11, 0x22, 0x33 in order, no loss.
- Flush with stage FULL and a simultaneous Valid_In -> next cycle Valid_Out=0, Ctrl_Out=SAFE_CTRL, Occupancy=0, Ready_Out=1; the flushed and incoming entries never appear.
- Drain to empty after ctrl 0x3 is popped -> Ctrl_Out=0x0 the same cycle Valid_Out falls (REG_W_En safe).
- RST asserted while FULL with Flush=1 and Valid_In=1 -> reset values next cycle; a new push afterwards emerges with latency 1.
